// File: rtl/dynamixel_rc_scheduler_pkg.sv
// Shared constants, FSM encoding and the RC-to-position mapping helper for the
// Dynamixel RC scheduler.
package dynamixel_rc_scheduler_pkg;

  localparam logic [15:0] ADDR_TORQUE_ENABLE = 16'd64;
  localparam logic [15:0] ADDR_GOAL_POSITION = 16'd116;
  localparam logic [15:0] LEN_TORQUE         = 16'd1;
  localparam logic [15:0] LEN_POSITION       = 16'd4;
  localparam logic [10:0] FPORT_CH_MID       = 11'd992;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } sched_state_e;

  // Clamp first so the subtraction can never wrap.
  function automatic logic [31:0] map_position(input logic [10:0] raw,
                                               input logic [10:0] ch_min,
                                               input logic [10:0] ch_max,
                                               input int unsigned shift);
    logic [10:0] clamped;
    logic [10:0] offset;
    if (raw < ch_min)      clamped = ch_min;
    else if (raw > ch_max) clamped = ch_max;
    else                   clamped = raw;
    offset = clamped - ch_min;
    return {21'd0, offset} << shift;
  endfunction

endpackage

// File: rtl/dynamixel_rc_scheduler_rc_channel_mapper.sv
// Converts RC channel strobes into per-servo Goal Position shadows
// (clamp, offset, shift) held in a registered array.
module rc_channel_mapper
  import dynamixel_rc_scheduler_pkg::*;
#(
  parameter int NUM_SERVOS = 4,
  parameter int CH_MIN     = 172,
  parameter int CH_MAX     = 1811,
  parameter int POS_SHIFT  = 1
) (
  input  logic                    clock_i,
  input  logic                    reset_ni,
  input  logic                    strobe_i,
  input  logic [3:0]              index_i,
  input  logic [10:0]             value_i,
  output logic [NUM_SERVOS*32-1:0] shadow_o
);

  logic [31:0] position;

  assign position = map_position(value_i, 11'(CH_MIN), 11'(CH_MAX), POS_SHIFT);

  for (genvar gi = 0; gi < NUM_SERVOS; gi++) begin : g_slot
    logic [31:0] slot_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        slot_q <= '0;
      end else if (strobe_i && (index_i == 4'(gi))) begin
        slot_q <= position;
      end
    end

    assign shadow_o[32*gi +: 32] = slot_q;
  end

endmodule

// File: rtl/dynamixel_rc_scheduler.sv
// Schedules Dynamixel sync-writes (torque on change, positions on refresh) from
// RC channel strobes. Optional RC link watchdog: define RC_FAILSAFE_EN.
module dynamixel_rc_scheduler
  import dynamixel_rc_scheduler_pkg::*;
#(
  parameter int clock_frequency = 12000000,
  parameter int NUM_SERVOS      = 4,
  parameter int TORQUE_CHANNEL  = 4,
  parameter int REFRESH_HZ      = 50,
  parameter int CH_MIN          = 172,
  parameter int CH_MAX          = 1811,
  parameter int POS_SHIFT       = 1,
  parameter int START_TIMEOUT   = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     channel_changed,
  input  logic [3:0]               channel_index,
  input  logic [10:0]              channel_value,
  input  logic                     writer_busy,
  output logic                     writer_send,
  output logic [15:0]              address,
  output logic [15:0]              data_len,
  output logic [NUM_SERVOS*32-1:0] values,
  output logic                     torque_on,
  output logic                     start_error
`ifdef RC_FAILSAFE_EN
  ,
  output logic                     failsafe
`endif
);

  localparam int REFRESH_PERIOD = clock_frequency / REFRESH_HZ;
  localparam int RW             = $clog2(REFRESH_PERIOD);
  localparam int TW             = $clog2(START_TIMEOUT + 1);

  sched_state_e              state_q;
  logic                      writer_send_q;
  logic [15:0]               address_q;
  logic [15:0]               data_len_q;
  logic [NUM_SERVOS*32-1:0]  values_q;
  logic                      start_error_q;
  logic [RW-1:0]             refresh_cnt_q;
  logic [TW-1:0]             timeout_q;
  logic                      torque_on_q, torque_on_d;
  logic                      torque_desired_q, torque_desired_d;
  logic                      torque_pending_q, torque_pending_d;
  logic                      refresh_pending_q, refresh_pending_d;
  logic [NUM_SERVOS*32-1:0]  shadow;
  logic                      latch_torque, latch_refresh, refresh_wrap, torque_strobe;
  logic                      wd_expire;

  rc_channel_mapper #(
    .NUM_SERVOS(NUM_SERVOS),
    .CH_MIN    (CH_MIN),
    .CH_MAX    (CH_MAX),
    .POS_SHIFT (POS_SHIFT)
  ) u_mapper (
    .clock_i (clock),
    .reset_ni(reset_n),
    .strobe_i(channel_changed),
    .index_i (channel_index),
    .value_i (channel_value),
    .shadow_o(shadow)
  );

`ifdef RC_FAILSAFE_EN
  localparam int WD_LIMIT = clock_frequency / 10;
  localparam int WW       = $clog2(WD_LIMIT + 1);

  logic [WW-1:0] wd_cnt_q;
  logic          failsafe_q;

  assign wd_expire = (wd_cnt_q == WW'(WD_LIMIT - 1)) && !channel_changed;
  assign failsafe  = failsafe_q;

  // Saturates at the limit so the failsafe fires once per link loss.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q   <= '0;
      failsafe_q <= 1'b0;
    end else if (channel_changed) begin
      wd_cnt_q   <= '0;
      failsafe_q <= 1'b0;
    end else begin
      if (wd_cnt_q != WW'(WD_LIMIT)) wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_expire) failsafe_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  assign refresh_wrap  = (refresh_cnt_q == RW'(REFRESH_PERIOD - 1));
  assign torque_strobe = channel_changed && (channel_index == 4'(TORQUE_CHANNEL));
  assign latch_torque  = (state_q == ST_IDLE) && torque_pending_q;
  assign latch_refresh = (state_q == ST_IDLE) && !torque_pending_q && refresh_pending_q;

  // Pending flags compare against the torque state that will hold after this
  // cycle's latch, so a request cancelled before it is issued costs nothing.
  always_comb begin
    torque_on_d       = latch_torque ? torque_desired_q : torque_on_q;
    torque_desired_d  = torque_desired_q;
    torque_pending_d  = torque_pending_q && !latch_torque;
    refresh_pending_d = refresh_pending_q && !latch_refresh;
    if (torque_strobe) begin
      torque_desired_d = (channel_value > FPORT_CH_MID);
      torque_pending_d = (torque_desired_d != torque_on_d);
    end else if (wd_expire) begin
      torque_desired_d = 1'b0;
      torque_pending_d = torque_on_d;
    end
    if (refresh_wrap && torque_on_q) refresh_pending_d = 1'b1;
    if (latch_torque && !torque_desired_q) refresh_pending_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      writer_send_q     <= 1'b0;
      address_q         <= '0;
      data_len_q        <= '0;
      values_q          <= '0;
      start_error_q     <= 1'b0;
      refresh_cnt_q     <= '0;
      timeout_q         <= '0;
      torque_on_q       <= 1'b0;
      torque_desired_q  <= 1'b0;
      torque_pending_q  <= 1'b0;
      refresh_pending_q <= 1'b0;
    end else begin
      writer_send_q     <= 1'b0;
      refresh_cnt_q     <= refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
      torque_on_q       <= torque_on_d;
      torque_desired_q  <= torque_desired_d;
      torque_pending_q  <= torque_pending_d;
      refresh_pending_q <= refresh_pending_d;
      case (state_q)
        ST_IDLE: begin
          if (latch_torque) begin
            address_q     <= ADDR_TORQUE_ENABLE;
            data_len_q    <= LEN_TORQUE;
            values_q      <= {NUM_SERVOS{{31'd0, torque_desired_q}}};
            writer_send_q <= 1'b1;
            state_q       <= ST_SEND;
          end else if (latch_refresh) begin
            address_q     <= ADDR_GOAL_POSITION;
            data_len_q    <= LEN_POSITION;
            values_q      <= shadow;
            writer_send_q <= 1'b1;
            state_q       <= ST_SEND;
          end
        end
        ST_SEND: begin
          timeout_q <= '0;
          state_q   <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (writer_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (timeout_q == TW'(START_TIMEOUT - 1)) begin
            start_error_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!writer_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign writer_send = writer_send_q;
  assign address     = address_q;
  assign data_len    = data_len_q;
  assign values      = values_q;
  assign torque_on   = torque_on_q;
  assign start_error = start_error_q;

endmodule

// File: tb/tb_dynamixel_rc_scheduler.sv
// Scoreboard bench for dynamixel_rc_scheduler: randomized RC strobes, a writer
// model with random busy timing, and a spec-level model of expected sync-writes.
module tb_dynamixel_rc_scheduler;

  localparam int CLK_F = 10000;
  localparam int RHZ   = 50;
  localparam int P     = CLK_F / RHZ;
  localparam int NUM   = 4;
  localparam int TCH   = 4;
  localparam int TO    = 15;
  localparam int W     = NUM * 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          channel_changed;
  logic [3:0]    channel_index;
  logic [10:0]   channel_value;
  logic          writer_busy;
  logic          writer_send;
  logic [15:0]   address;
  logic [15:0]   data_len;
  logic [W-1:0]  values;
  logic          torque_on;
  logic          start_error;
`ifdef RC_FAILSAFE_EN
  logic          failsafe;
`endif

  dynamixel_rc_scheduler #(
    .clock_frequency(CLK_F),
    .NUM_SERVOS     (NUM),
    .TORQUE_CHANNEL (TCH),
    .REFRESH_HZ     (RHZ),
    .CH_MIN         (172),
    .CH_MAX         (1811),
    .POS_SHIFT      (1),
    .START_TIMEOUT  (TO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .channel_changed(channel_changed),
    .channel_index  (channel_index),
    .channel_value  (channel_value),
    .writer_busy    (writer_busy),
    .writer_send    (writer_send),
    .address        (address),
    .data_len       (data_len),
    .values         (values),
    .torque_on      (torque_on),
    .start_error    (start_error)
`ifdef RC_FAILSAFE_EN
    ,
    .failsafe       (failsafe)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]  addr;
    logic [15:0]  len;
    logic [W-1:0] vals;
    logic         tq;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          send_count = 0;
  int          exp_sends = 0;
  int          cycle = 0;
  int          last_send_cycle = 0;
  bit          no_busy = 0;
  logic [31:0] shadow_m[NUM];
  bit          tq_m = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pos_of(input int v);
    int c;
    c = (v < 172) ? 172 : ((v > 1811) ? 1811 : v);
    return 32'((c - 172) * 2);
  endfunction

  always @(posedge clock) cycle <= cycle + 1;

  // Monitor: every send must match the oldest expected write.
  always @(negedge clock) begin
    if (reset_n && writer_send) begin
      send_count++;
      last_send_cycle = cycle;
      $display("send %0d @%0d addr=%0d len=%0d vals=%h torque_on=%0b",
               send_count, cycle, address, data_len, values, torque_on);
      check("busy_at_send", W'(writer_busy), W'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_send", W'(1), W'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("address", W'(address), W'(e.addr));
        check("data_len", W'(data_len), W'(e.len));
        check("values", values, e.vals);
        check("torque_on_at_send", W'(torque_on), W'(e.tq));
      end
    end
  end

  // Writer model: busy rises a few cycles after send and lasts a random time.
  initial begin
    writer_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && writer_send && !no_busy) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 writer_busy = 1'b1;
        repeat ($urandom_range(5, 30)) @(posedge clock);
        #1 writer_busy = 1'b0;
      end
    end
  end

  task automatic push_torque(input bit t);
    exp_t e;
    e.addr = 16'd64;
    e.len  = 16'd1;
    e.vals = '0;
    for (int i = 0; i < NUM; i++) e.vals[32*i] = t;
    e.tq = t;
    exp_q.push_back(e);
    exp_sends++;
  endtask

  task automatic push_refresh();
    exp_t e;
    e.addr = 16'd116;
    e.len  = 16'd4;
    for (int i = 0; i < NUM; i++) e.vals[32*i +: 32] = shadow_m[i];
    e.tq = 1'b1;
    exp_q.push_back(e);
    exp_sends++;
  endtask

  task automatic strobe(input int idx, input int val);
    if (idx < NUM) shadow_m[idx] = pos_of(val);
    if (idx == TCH && ((val > 992) != tq_m)) begin
      tq_m = (val > 992);
      push_torque(tq_m);
    end
    @(posedge clock);
    #1;
    channel_changed = 1'b1;
    channel_index   = 4'(idx);
    channel_value   = 11'(val);
    @(posedge clock);
    #1 channel_changed = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (send_count < target && n < 4 * P) begin
      @(negedge clock);
      n++;
    end
    check("send_count", W'(send_count), W'(target));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!writer_busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("busy_seen", W'(writer_busy), W'(1));
  endtask

  task automatic quiet(input string name);
    int base;
    base = send_count;
    repeat (3 * P) @(negedge clock);
    check(name, W'(send_count), W'(base));
  endtask

  task automatic window(input int nstrobes);
    int idx, val;
    repeat ($urandom_range(0, 20)) @(posedge clock);
    for (int k = 0; k < nstrobes; k++) begin
      idx = $urandom_range(0, 15);
      val = (idx == TCH) ? $urandom_range(993, 2047) : $urandom_range(0, 2047);
      strobe(idx, val);
    end
  endtask

  initial begin
    int t0;
    reset_n = 1'b0;
    channel_changed = 1'b0;
    channel_index = '0;
    channel_value = '0;
    for (int i = 0; i < NUM; i++) shadow_m[i] = '0;

    // Reset state
    repeat (5) @(negedge clock);
    check("rst_send", W'(writer_send), W'(0));
    check("rst_address", W'(address), W'(0));
    check("rst_len", W'(data_len), W'(0));
    check("rst_values", values, W'(0));
    check("rst_torque_on", W'(torque_on), W'(0));
    check("rst_start_error", W'(start_error), W'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;
    quiet("no_send_torque_off");

    // Torque on, then periodic refreshes
    repeat ($urandom_range(1, 50)) @(posedge clock);
    strobe(TCH, 1811);
    push_refresh();
    wait_until(exp_sends);
    check("torque_on_after_on", W'(torque_on), W'(1));
    push_refresh();
    wait_until(exp_sends);
    for (int r = 0; r < 2; r++) begin
      t0 = last_send_cycle;
      push_refresh();
      wait_until(exp_sends);
      check("refresh_period", W'(last_send_cycle - t0), W'(P));
    end

    // Clamp boundaries on channel 1 and channel 0 low clamp
    strobe(1, 172);
    push_refresh();
    wait_until(exp_sends);
    strobe(1, 1811);
    push_refresh();
    wait_until(exp_sends);
    strobe(1, 2047);
    strobe(0, 0);
    push_refresh();
    wait_until(exp_sends);

    // Randomized strobes between refreshes
    for (int r = 0; r < 12; r++) begin
      window($urandom_range(1, 3));
      push_refresh();
      wait_until(exp_sends);
    end

    // Torque off (value 992 is not above mid) while a position write is busy
    wait_busy();
    strobe(TCH, 992);
    wait_until(exp_sends);
    check("torque_on_after_off", W'(torque_on), W'(0));
    quiet("no_refresh_torque_off");

    // Writer never starts
    no_busy = 1;
    strobe(TCH, 1811);
    push_refresh();
    wait_until(exp_sends - 1);
    check("start_error_early", W'(start_error), W'(0));
    repeat (TO + 3) @(negedge clock);
    check("start_error_set", W'(start_error), W'(1));
    check("torque_on_dropped_write", W'(torque_on), W'(1));
    no_busy = 0;
    wait_until(exp_sends);
    check("start_error_sticky", W'(start_error), W'(1));

    // Reset mid-write
    push_refresh();
    wait_until(exp_sends);
    wait_busy();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    check("midrst_send", W'(writer_send), W'(0));
    check("midrst_values", values, W'(0));
    check("midrst_torque_on", W'(torque_on), W'(0));
    check("midrst_start_error", W'(start_error), W'(0));
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tq_m = 0;
    for (int i = 0; i < NUM; i++) shadow_m[i] = '0;
    quiet("no_send_after_reset");
    strobe(TCH, 993);
    push_refresh();
    wait_until(exp_sends);
    repeat (5) @(negedge clock);
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
